// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with configurable width/depth, occupancy count,
// almost-full/almost-empty thresholds, sticky error flags and flush.
module param_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  parameter  int AF_TH = 6,
  parameter  int AE_TH = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);

  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_AF    = (AW+1)'(AF_TH);
  localparam logic [AW:0] L_AE    = (AW+1)'(AE_TH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_dout;
  logic             r_dv;
  logic             r_ovf;
  logic             r_udf;

  logic [AW:0]      w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_wr_ok;
  logic             w_rd_ok;

  // Wrap bit makes full and empty distinguishable with equal low bits.
  assign w_count = r_wptr - r_rptr;
  assign w_full  = (w_count == L_DEPTH);
  assign w_empty = (w_count == '0);
  assign w_wr_ok = wr_en & ~w_full & ~flush;
  assign w_rd_ok = rd_en & ~w_empty & ~flush;

  // Storage; contents are don't-care after reset.
  always_ff @(posedge clock) begin
    if (w_wr_ok) r_mem[r_wptr[AW-1:0]] <= din;
  end

  // Pointer advance, or clear on flush.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
      if (w_rd_ok) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Registered read data with a one-cycle valid pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dout <= '0;
      r_dv   <= 1'b0;
    end else begin
      r_dv <= w_rd_ok;
      if (w_rd_ok) r_dout <= r_mem[r_rptr[AW-1:0]];
    end
  end

  // Sticky error flags; a new error beats a clear in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (!flush) begin
      r_ovf <= (wr_en & w_full) | (r_ovf & ~err_clr);
      r_udf <= (rd_en & w_empty) | (r_udf & ~err_clr);
    end
  end

  assign dout         = r_dout;
  assign dout_valid   = r_dv;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (w_count >= L_AF);
  assign almost_empty = (w_count <= L_AE);
  assign count        = w_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
Single-clock, parametrised first-in-first-out buffer. It generalises the team's 8x8 FIFO with configurable width and depth, and all DEPTH entries are usable. It supports a simultaneous read and write in the same cycle, and adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. It sits between producer and consumer blocks in the same clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AF_TH, 6, almost_full asserted when count >= AF_TH (1..DEPTH)
AE_TH, 1, almost_empty asserted when count <= AE_TH (0..DEPTH-1)
Derived: AW = clog2(DEPTH); pointers and count are AW+1 bits wide.

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
flush  in  1  synchronous clear of pointers
wr_en  in  1  write request
din  in  WIDTH  write data
rd_en  in  1  read request
dout  out  WIDTH  registered read data
dout_valid  out  1  one-cycle pulse: dout updated this cycle
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_TH
almost_empty  out  1  count <= AE_TH
count  out  AW+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a write was rejected
underflow  out  1  sticky: a read was rejected
err_clr  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (reset=0, asynchronous): wptr=rptr=0, dout=0, dout_valid=0, overflow=underflow=0. Outputs are immediately empty=1, full=0, count=0, almost_empty=1, almost_full=(AF_TH==0 ? 1 : 0). Memory array is not reset. Reset mid-operation discards all contents.
- Pointers: AW+1 bits. The low AW bits index memory; the MSB is a wrap bit. count = wptr - rptr (modulo 2^(AW+1)). full/empty/almost flags are combinational from the registered pointers.
- Write accept: wr_en & !full. Stores din at mem[wptr[AW-1:0]]; wptr += 1 at the clock edge.
- Read accept: rd_en & !empty. Registers dout <= mem[rptr[AW-1:0]] and rptr += 1; dout_valid=1 for the following cycle. Read latency is 1 clock. dout holds its last value when no read is accepted, and dout_valid=0.
- Simultaneous wr_en & rd_en:
  - Not full and not empty: both accepted; count unchanged.
  - Full: read accepted, write rejected; overflow set.
  - Empty: write accepted, read rejected; underflow set. There is no write-through bypass.
- Wrap-around: pointers roll over naturally from 2^(AW+1)-1 to 0. Ordering is preserved across the wrap.
- overflow is set on wr_en & full. underflow is set on rd_en & empty. Both flags are sticky until err_clr=1. If a set and err_clr occur in the same cycle, the set wins.
- flush=1 at a clock edge:
  - wptr=rptr=0 and dout_valid=0.
  - Any wr_en/rd_en in the same cycle is ignored and flags no errors.
  - dout and the error flags are unchanged.
- No combinational path from wr_en/rd_en to any output. All outputs derive from registers.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, dout=0, almost_empty=1, overflow=underflow=0.
- DEPTH=8: write 0x01..0x08 on 8 cycles -> count=8, full=1, almost_full from count=6. Then 8 reads -> dout 0x01..0x08, each with a dout_valid pulse one cycle after rd_en, ending with empty=1.
- Fill to 8, then one cycle with wr_en=rd_en=1 and din=0xAA -> 0xAA rejected, overflow=1, count=7. err_clr -> overflow=0.
- From empty, wr_en=rd_en=1 with din=0x55 -> count=1, underflow=1, dout_valid=0. The next read returns 0x55.
- Stream 20 words with rd/wr interleaved and simultaneous at count=3 -> count steady, output order 0..19 intact across pointer wrap.
- Count=5 and reset pulsed low mid-cycle -> empty=1, count=0 asynchronously, before the next edge. Separately, flush with wr_en=1 at count=4 -> count=0 and the write is dropped.
